// File: rtl/apb_timer_responder.sv
// APB completer exposing a prescaled down-counting timer with interrupt,
// plus a programmable number of wait states inserted into every transfer.
module apb_timer_responder #(
    parameter int          ADDR_W        = 12,
    parameter logic [3:0]  WAIT_INIT     = 4'd0,
    parameter logic [15:0] PRESCALE_INIT = 16'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic        irq
);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    localparam logic [ADDR_W-1:0] OFF_CTRL     = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] OFF_PRESCALE = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] OFF_LOAD     = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] OFF_COUNT    = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] OFF_STATUS   = ADDR_W'(32'h10);
    localparam logic [ADDR_W-1:0] OFF_WAIT     = ADDR_W'(32'h14);

    state_t      r_state, w_stateNext;
    logic [3:0]  r_wcnt, w_wcntNext;
    logic [2:0]  r_ctrl, w_ctrlNext;
    logic [15:0] r_prescale;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_pend, w_pendNext;
    logic [3:0]  r_wait;
    logic [15:0] r_pcnt;
    logic        r_irq;

    logic [ADDR_W-1:0] w_offset;
    logic w_selCtrl, w_selPrescale, w_selLoad, w_selCount, w_selStatus, w_selWait;
    logic w_err, w_ready, w_wrEn, w_tick, w_loadWr, w_presWr, w_pendSet, w_pendClr;
    logic [31:0] w_mask, w_loadNew, w_rdata;
    logic w_unused;

    assign w_unused = ^{in_pprot, in_paddr[31:ADDR_W]};

    // Misaligned addresses never match an offset, so they fall into the error path.
    assign w_offset      = in_paddr[ADDR_W-1:0];
    assign w_selCtrl     = (w_offset == OFF_CTRL);
    assign w_selPrescale = (w_offset == OFF_PRESCALE);
    assign w_selLoad     = (w_offset == OFF_LOAD);
    assign w_selCount    = (w_offset == OFF_COUNT);
    assign w_selStatus   = (w_offset == OFF_STATUS);
    assign w_selWait     = (w_offset == OFF_WAIT);
    assign w_err = !(w_selCtrl | w_selPrescale | w_selLoad | w_selCount | w_selStatus | w_selWait)
                 | (in_pwrite & w_selCount);

    assign w_ready = (r_state == ST_ACCESS) && in_psel && in_penable && (r_wcnt == 4'd0);
    assign w_wrEn  = w_ready && in_pwrite && !w_err;

    assign w_mask    = {{8{in_pstrb[3]}}, {8{in_pstrb[2]}}, {8{in_pstrb[1]}}, {8{in_pstrb[0]}}};
    assign w_loadNew = (r_load & ~w_mask) | (in_pwdata & w_mask);

    always_comb begin
        w_stateNext = r_state;
        w_wcntNext  = r_wcnt;
        case (r_state)
            ST_IDLE: begin
                if (in_psel && !in_penable) begin
                    w_stateNext = ST_ACCESS;
                    w_wcntNext  = r_wait;
                end
            end
            ST_ACCESS: begin
                if (!in_psel) begin
                    w_stateNext = ST_IDLE;
                end else if (in_penable) begin
                    if (r_wcnt == 4'd0) begin
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_wcntNext = r_wcnt - 4'd1;
                    end
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_wcnt  <= w_wcntNext;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_selCtrl)     w_rdata = {29'd0, r_ctrl};
        if (w_selPrescale) w_rdata = {16'd0, r_prescale};
        if (w_selLoad)     w_rdata = r_load;
        if (w_selCount)    w_rdata = r_count;
        if (w_selStatus)   w_rdata = {31'd0, r_pend};
        if (w_selWait)     w_rdata = {28'd0, r_wait};
    end

    assign in_pready  = w_ready;
    assign in_prdata  = (w_ready && !w_err) ? w_rdata : 32'd0;
    assign in_pslverr = w_ready && w_err;

    // A LOAD write takes priority over a coincident tick, which is dropped entirely.
    assign w_tick    = r_ctrl[0] && (r_pcnt == r_prescale);
    assign w_loadWr  = w_wrEn && w_selLoad;
    assign w_presWr  = w_wrEn && w_selPrescale;
    assign w_pendSet = w_tick && !w_loadWr && (r_count == 32'd1);
    assign w_pendClr = w_wrEn && w_selStatus && in_pstrb[0] && in_pwdata[0];
    assign w_pendNext = w_pendSet ? 1'b1 : (w_pendClr ? 1'b0 : r_pend);
    assign w_ctrlNext = (w_wrEn && w_selCtrl && in_pstrb[0]) ? in_pwdata[2:0] : r_ctrl;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ctrl     <= 3'd0;
            r_prescale <= PRESCALE_INIT;
            r_load     <= 32'd0;
            r_wait     <= WAIT_INIT;
            r_pend     <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_ctrl <= w_ctrlNext;
            r_pend <= w_pendNext;
            r_irq  <= w_pendNext & w_ctrlNext[1];
            if (w_presWr && in_pstrb[0]) r_prescale[7:0]  <= in_pwdata[7:0];
            if (w_presWr && in_pstrb[1]) r_prescale[15:8] <= in_pwdata[15:8];
            if (w_loadWr) r_load <= w_loadNew;
            if (w_wrEn && w_selWait && in_pstrb[0]) r_wait <= in_pwdata[3:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pcnt  <= 16'd0;
            r_count <= 32'd0;
        end else begin
            if (!r_ctrl[0] || w_presWr || w_loadWr || w_tick) begin
                r_pcnt <= 16'd0;
            end else begin
                r_pcnt <= r_pcnt + 16'd1;
            end

            if (w_loadWr) begin
                r_count <= w_loadNew;
            end else if (w_tick) begin
                if (r_count > 32'd1) begin
                    r_count <= r_count - 32'd1;
                end else if (r_count == 32'd1) begin
                    r_count <= r_ctrl[2] ? r_load : 32'd0;
                end
            end
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_apb_timer_responder.sv
// Directed bench for apb_timer_responder: bus handshakes, register map,
// timer/interrupt behaviour, error responses, aborts and asynchronous reset.
module tb_apb_timer_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic [2:0]  in_pprot;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;
    logic        irq;

    int nAssert = 0;
    int nFail   = 0;

    logic [31:0] rdData;
    logic        rdErr;
    int          nWaits;

    apb_timer_responder #(.ADDR_W(12), .WAIT_INIT(4'd0), .PRESCALE_INIT(16'd0)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_paddr   (in_paddr),
        .in_psel    (in_psel),
        .in_penable (in_penable),
        .in_pprot   (in_pprot),
        .in_pwrite  (in_pwrite),
        .in_pwdata  (in_pwdata),
        .in_pstrb   (in_pstrb),
        .in_pready  (in_pready),
        .in_prdata  (in_prdata),
        .in_pslverr (in_pslverr),
        .irq        (irq)
    );

    always #5 clock = ~clock;

    // Entered and left 1ns after a rising edge; consecutive calls run back-to-back.
    task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                 input logic [3:0] strb, output logic [31:0] rdata,
                                 output logic err, output int waits);
        bit done;
        in_psel = 1'b1; in_penable = 1'b0; in_paddr = addr;
        in_pwrite = wr; in_pwdata = wdata; in_pstrb = strb;
        @(posedge clock); #1;
        in_penable = 1'b1;
        waits = 0; done = 1'b0; rdata = 32'd0; err = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #3;
            if (in_pready === 1'b1) begin
                done  = 1'b1;
                rdata = in_prdata;
                err   = in_pslverr;
            end else begin
                waits++;
            end
            @(posedge clock); #1;
        end
        if (!done) begin
            nAssert++; nFail++;
            $display("[TB] FAIL xfer_timeout: addr %h got no pready, required pready within 40 cycles", addr);
        end
        in_psel = 1'b0; in_penable = 1'b0;
    endtask

    task automatic test_reset;
        nAssert++;
        if ({in_pready, in_pslverr, irq} !== 3'b000 || in_prdata !== 32'd0) begin
            nFail++;
            $display("[TB] FAIL reset_outputs: got rdy=%b err=%b irq=%b rdata=%h required all 0",
                     in_pready, in_pslverr, irq, in_prdata);
        end
        applyStimulus(32'h14, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd0 || nWaits !== 0) begin
            nFail++; $display("[TB] FAIL reset_wait: got %h waits %0d required 0 waits 0", rdData, nWaits);
        end
        applyStimulus(32'h04, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd0) begin nFail++; $display("[TB] FAIL reset_prescale: got %h required 0", rdData); end
        applyStimulus(32'h00, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd0) begin nFail++; $display("[TB] FAIL reset_ctrl: got %h required 0", rdData); end
        applyStimulus(32'h10, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd0) begin nFail++; $display("[TB] FAIL reset_status: got %h required 0", rdData); end
    endtask

    task automatic test_zero_wait;
        applyStimulus(32'h08, 1'b1, 32'd5, 4'hF, rdData, rdErr, nWaits);
        nAssert++;
        if (rdErr !== 1'b0 || nWaits !== 0) begin
            nFail++; $display("[TB] FAIL zw_write: got err %b waits %0d required 0 0", rdErr, nWaits);
        end
        applyStimulus(32'h08, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd5 || nWaits !== 0) begin
            nFail++; $display("[TB] FAIL zw_load: got %h waits %0d required 5 waits 0", rdData, nWaits);
        end
        applyStimulus(32'h0C, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd5) begin nFail++; $display("[TB] FAIL zw_count: got %h required 5", rdData); end
    endtask

    task automatic test_wait_states;
        applyStimulus(32'h14, 1'b1, 32'd3, 4'hF, rdData, rdErr, nWaits);
        nAssert++;
        if (nWaits !== 0) begin nFail++; $display("[TB] FAIL ws_set: got waits %0d required 0", nWaits); end
        applyStimulus(32'h00, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (nWaits !== 3 || rdData !== 32'd0) begin
            nFail++; $display("[TB] FAIL ws_read: got waits %0d data %h required 3 0", nWaits, rdData);
        end
        applyStimulus(32'h04, 1'b1, 32'h0000_0002, 4'hF, rdData, rdErr, nWaits);
        nAssert++;
        if (nWaits !== 3) begin nFail++; $display("[TB] FAIL ws_write: got waits %0d required 3", nWaits); end
        applyStimulus(32'h04, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd2) begin nFail++; $display("[TB] FAIL ws_prescale: got %h required 2", rdData); end
        applyStimulus(32'h14, 1'b1, 32'd0, 4'hF, rdData, rdErr, nWaits);
        nAssert++;
        if (nWaits !== 3) begin nFail++; $display("[TB] FAIL ws_clear: got waits %0d required 3", nWaits); end
        applyStimulus(32'h14, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (nWaits !== 0 || rdData !== 32'd0) begin
            nFail++; $display("[TB] FAIL ws_after: got waits %0d data %h required 0 0", nWaits, rdData);
        end
    endtask

    task automatic test_errors;
        applyStimulus(32'h0C, 1'b1, 32'h99, 4'hF, rdData, rdErr, nWaits);
        nAssert++;
        if (rdErr !== 1'b1 || rdData !== 32'd0) begin
            nFail++; $display("[TB] FAIL err_count_wr: got err %b data %h required 1 0", rdErr, rdData);
        end
        applyStimulus(32'h0C, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdErr !== 1'b0 || rdData !== 32'd5) begin
            nFail++; $display("[TB] FAIL err_count_kept: got err %b data %h required 0 5", rdErr, rdData);
        end
        applyStimulus(32'h18, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdErr !== 1'b1 || rdData !== 32'd0) begin
            nFail++; $display("[TB] FAIL err_unmapped: got err %b data %h required 1 0", rdErr, rdData);
        end
        applyStimulus(32'h02, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdErr !== 1'b1 || rdData !== 32'd0) begin
            nFail++; $display("[TB] FAIL err_misaligned: got err %b data %h required 1 0", rdErr, rdData);
        end
        applyStimulus(32'h06, 1'b1, 32'h0000_FFFF, 4'hF, rdData, rdErr, nWaits);
        nAssert++;
        if (rdErr !== 1'b1) begin nFail++; $display("[TB] FAIL err_misaligned_wr: got err %b required 1", rdErr); end
        applyStimulus(32'h04, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd2) begin nFail++; $display("[TB] FAIL err_no_effect: got %h required 2", rdData); end
    endtask

    task automatic test_byte_strobes;
        applyStimulus(32'h08, 1'b1, 32'd0, 4'hF, rdData, rdErr, nWaits);
        applyStimulus(32'h08, 1'b1, 32'hAABB_CCDD, 4'b0001, rdData, rdErr, nWaits);
        applyStimulus(32'h08, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'h0000_00DD) begin nFail++; $display("[TB] FAIL strb_lane0: got %h required 000000dd", rdData); end
        applyStimulus(32'h08, 1'b1, 32'h1122_3344, 4'b0100, rdData, rdErr, nWaits);
        applyStimulus(32'h08, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'h0022_00DD) begin nFail++; $display("[TB] FAIL strb_lane2: got %h required 002200dd", rdData); end
    endtask

    task automatic test_timer_oneshot;
        logic [31:0] expSeq [4];
        expSeq = '{32'd3, 32'd2, 32'd1, 32'd0};
        applyStimulus(32'h04, 1'b1, 32'd1, 4'hF, rdData, rdErr, nWaits);
        applyStimulus(32'h08, 1'b1, 32'd3, 4'hF, rdData, rdErr, nWaits);
        applyStimulus(32'h00, 1'b1, 32'h3, 4'hF, rdData, rdErr, nWaits);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h0C, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
            nAssert++;
            if (rdData !== expSeq[i]) begin
                nFail++; $display("[TB] FAIL os_count%0d: got %h required %h", i, rdData, expSeq[i]);
            end
        end
        applyStimulus(32'h10, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd1 || irq !== 1'b1) begin
            nFail++; $display("[TB] FAIL os_pend_irq: got pend %h irq %b required 1 1", rdData, irq);
        end
        applyStimulus(32'h0C, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd0) begin nFail++; $display("[TB] FAIL os_count_hold: got %h required 0", rdData); end
        applyStimulus(32'h10, 1'b1, 32'd1, 4'hF, rdData, rdErr, nWaits);
        applyStimulus(32'h10, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd0 || irq !== 1'b0) begin
            nFail++; $display("[TB] FAIL os_w1c: got pend %h irq %b required 0 0", rdData, irq);
        end
        applyStimulus(32'h00, 1'b1, 32'd0, 4'hF, rdData, rdErr, nWaits);
    endtask

    task automatic test_auto_reload;
        applyStimulus(32'h04, 1'b1, 32'd0, 4'hF, rdData, rdErr, nWaits);
        applyStimulus(32'h08, 1'b1, 32'd2, 4'hF, rdData, rdErr, nWaits);
        applyStimulus(32'h00, 1'b1, 32'h5, 4'hF, rdData, rdErr, nWaits);
        applyStimulus(32'h0C, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd1) begin nFail++; $display("[TB] FAIL ar_count_a: got %h required 1", rdData); end
        applyStimulus(32'h0C, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd1) begin nFail++; $display("[TB] FAIL ar_count_b: got %h required 1", rdData); end
        @(posedge clock); #1;
        applyStimulus(32'h0C, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd2) begin nFail++; $display("[TB] FAIL ar_count_reload: got %h required 2", rdData); end
        applyStimulus(32'h10, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd1 || irq !== 1'b0) begin
            nFail++; $display("[TB] FAIL ar_pend: got pend %h irq %b required 1 0", rdData, irq);
        end
        applyStimulus(32'h08, 1'b1, 32'd7, 4'hF, rdData, rdErr, nWaits);
        applyStimulus(32'h0C, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd6) begin nFail++; $display("[TB] FAIL ar_load_vs_tick: got %h required 6", rdData); end
        applyStimulus(32'h0C, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd4) begin nFail++; $display("[TB] FAIL ar_after_load: got %h required 4", rdData); end
        applyStimulus(32'h00, 1'b1, 32'd0, 4'hF, rdData, rdErr, nWaits);
        applyStimulus(32'h10, 1'b1, 32'd1, 4'hF, rdData, rdErr, nWaits);
    endtask

    task automatic test_abort;
        applyStimulus(32'h14, 1'b1, 32'd5, 4'hF, rdData, rdErr, nWaits);
        in_psel = 1'b1; in_penable = 1'b0; in_paddr = 32'h00;
        in_pwrite = 1'b1; in_pwdata = 32'h7; in_pstrb = 4'hF;
        @(posedge clock); #1;
        in_penable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            nAssert++;
            if (in_pready !== 1'b0) begin
                nFail++; $display("[TB] FAIL abort_wait%0d: got pready %b required 0", i, in_pready);
            end
            @(posedge clock); #1;
        end
        in_psel = 1'b0; in_penable = 1'b0;
        @(posedge clock); #1;
        applyStimulus(32'h00, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd0 || nWaits !== 5) begin
            nFail++; $display("[TB] FAIL abort_no_commit: got ctrl %h waits %0d required 0 waits 5", rdData, nWaits);
        end
        applyStimulus(32'h14, 1'b1, 32'd0, 4'hF, rdData, rdErr, nWaits);
    endtask

    task automatic test_reset_mid_transfer;
        applyStimulus(32'h04, 1'b1, 32'd0, 4'hF, rdData, rdErr, nWaits);
        applyStimulus(32'h08, 1'b1, 32'd1, 4'hF, rdData, rdErr, nWaits);
        applyStimulus(32'h00, 1'b1, 32'h3, 4'hF, rdData, rdErr, nWaits);
        in_psel = 1'b1; in_penable = 1'b0; in_paddr = 32'h08; in_pwrite = 1'b0;
        @(posedge clock); #1;
        in_penable = 1'b1;
        #3;
        nAssert++;
        if (in_pready !== 1'b1 || in_prdata !== 32'd1 || irq !== 1'b1) begin
            nFail++; $display("[TB] FAIL rst_pre: got rdy %b data %h irq %b required 1 1 1", in_pready, in_prdata, irq);
        end
        reset = 1'b0;
        #1;
        nAssert++;
        if ({in_pready, in_pslverr, irq} !== 3'b000 || in_prdata !== 32'd0) begin
            nFail++; $display("[TB] FAIL rst_async: got rdy %b err %b irq %b data %h required all 0",
                              in_pready, in_pslverr, irq, in_prdata);
        end
        in_psel = 1'b0; in_penable = 1'b0;
        @(posedge clock); #3;
        reset = 1'b1;
        @(posedge clock); #1;
        applyStimulus(32'h08, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd0) begin nFail++; $display("[TB] FAIL rst_load_cleared: got %h required 0", rdData); end
        applyStimulus(32'h00, 1'b0, 32'd0, 4'h0, rdData, rdErr, nWaits);
        nAssert++;
        if (rdData !== 32'd0) begin nFail++; $display("[TB] FAIL rst_ctrl_cleared: got %h required 0", rdData); end
    endtask

    initial begin
        reset = 1'b0; in_paddr = 32'd0; in_psel = 1'b0; in_penable = 1'b0;
        in_pprot = 3'd0; in_pwrite = 1'b0; in_pwdata = 32'd0; in_pstrb = 4'h0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock); #1;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_errors();
        test_byte_strobes();
        test_timer_oneshot();
        test_auto_reload();
        test_abort();
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
